// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 4-digit seven-segment scan controller.
package seg_pkg;

    // All segments dark / all anodes off (both active-low).
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Lit anode patterns, one digit at a time.
    localparam logic [3:0] AN3_LIT = 4'b0111;
    localparam logic [3:0] AN2_LIT = 4'b1011;
    localparam logic [3:0] AN1_LIT = 4'b1101;
    localparam logic [3:0] AN0_LIT = 4'b1110;

    // Active-low glyphs {dp,g..a}.
    localparam logic [7:0] GLYPH_H = 8'h89;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_L = 8'hC7;
    localparam logic [7:0] GLYPH_O = 8'hC0;
    localparam logic [7:0] GLYPH_Y = 8'h91;

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_e;

    // Anode pattern lighting digit idx.
    function automatic logic [3:0] an_lit(input logic [1:0] idx);
        logic [3:0] pat;
        case (idx)
            2'd3:    pat = AN3_LIT;
            2'd2:    pat = AN2_LIT;
            2'd1:    pat = AN1_LIT;
            default: pat = AN0_LIT;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot counter: counts up from 0, reports terminal count, cleared by load.
module seg_slot_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_last,
    output logic             o_tc_c
);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc_c = (r_cnt == i_last);

    // Count up, holding at terminal (never wraps); load clears on state change.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (!o_tc_c) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scanner with tear-free double-buffered frames.
// Optional SEG_BLANK_EN macro inserts an all-off guard period after each digit.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_TICKS = 100000,
    parameter int unsigned BLANK_TICKS   = 1000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        wr_valid_in,
    output logic        wr_ready_out,
    input  logic [31:0] wr_data_in,
    input  logic [3:0]  digit_en_in,
    output logic [3:0]  anode_out,
    output logic [7:0]  digit_out,
    output logic        frame_out
);

    localparam int unsigned MAX_TICKS = (REFRESH_TICKS > BLANK_TICKS) ? REFRESH_TICKS : BLANK_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);

    scan_state_e r_state;
    logic [1:0]  r_idx;
    logic [31:0] r_active;
    logic [31:0] r_shadow;
    logic        r_pending;
    logic        r_ready;
    logic [3:0]  r_anode;
    logic [7:0]  r_digit;
    logic        r_frame;

    logic             w_tc;
    logic [CNT_W-1:0] w_last;
    logic             w_boundary;
    logic             w_lit_en;
    logic             w_accept;
    logic             w_commit;

`ifdef SEG_BLANK_EN
    assign w_last     = (r_state == ST_SHOW) ? CNT_W'(REFRESH_TICKS - 1) : CNT_W'(BLANK_TICKS - 1);
    assign w_boundary = w_tc && (r_state == ST_BLANK) && (r_idx == 2'd0);
`else
    assign w_last     = CNT_W'(REFRESH_TICKS - 1);
    assign w_boundary = w_tc && (r_idx == 2'd0);
`endif

    assign w_lit_en = (r_state == ST_SHOW) && digit_en_in[r_idx];
    assign w_accept = wr_valid_in && r_ready;
    assign w_commit = w_boundary && r_pending;

    // Every terminal count is a state or digit change, so it also clears the counter.
    seg_slot_timer #(
        .CNT_W (CNT_W)
    ) u_slot_timer (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_load  (w_tc),
        .i_last  (w_last),
        .o_tc_c  (w_tc)
    );

    // Scan FSM and registered drive outputs (outputs lag state by one cycle).
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state <= ST_SHOW;
            r_idx   <= 2'd3;
            r_anode <= AN_OFF;
            r_digit <= SEG_OFF;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_boundary;
            r_anode <= w_lit_en ? an_lit(r_idx) : AN_OFF;
            r_digit <= w_lit_en ? r_active[{r_idx, 3'b000} +: 8] : SEG_OFF;
            if (w_tc) begin
`ifdef SEG_BLANK_EN
                if (r_state == ST_SHOW) begin
                    r_state <= ST_BLANK;
                end else begin
                    r_state <= ST_SHOW;
                    r_idx   <= r_idx - 2'd1;
                end
`else
                r_idx <= r_idx - 2'd1;
`endif
            end
        end
    end

    // Write handshake and shadow/active buffers; commit only at frame boundary.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_active  <= {4{SEG_OFF}};
            r_shadow  <= {4{SEG_OFF}};
            r_pending <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shadow <= wr_data_in;
            end
            if (w_commit) begin
                r_active <= r_shadow;
            end
            if (w_accept) begin
                r_pending <= 1'b1;
                r_ready   <= 1'b0;
            end else if (w_commit) begin
                r_pending <= 1'b0;
                r_ready   <= 1'b1;
            end else begin
                r_ready   <= !r_pending;
            end
        end
    end

    assign wr_ready_out = r_ready;
    assign anode_out    = r_anode;
    assign digit_out    = r_digit;
    assign frame_out    = r_frame;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed, table-driven bench for seg_scan_ctrl (REFRESH_TICKS=4, BLANK_TICKS=2).
module tb_seg_scan_ctrl;

    localparam int RT = 4;
`ifdef SEG_BLANK_EN
    localparam int BT = 2;
`else
    localparam int BT = 0;
`endif
    localparam int S = RT + BT;
    localparam int P = 4 * S;
    localparam int BND = 99;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic [3:0]  digit_en;
    logic [3:0]  anode;
    logic [7:0]  digit;
    logic        frame;

    int n_cmp;
    int n_err;
    logic exp_ready;
    logic exp_pend;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] act;
        int          w1c;
        logic [31:0] w1d;
        int          w2c;
        logic [31:0] w2d;
    } vec_t;

    vec_t tbl[8];

    seg_scan_ctrl #(
        .REFRESH_TICKS (RT),
        .BLANK_TICKS   (2)
    ) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .wr_valid_in  (wr_valid),
        .wr_ready_out (wr_ready),
        .wr_data_in   (wr_data),
        .digit_en_in  (digit_en),
        .anode_out    (anode),
        .digit_out    (digit),
        .frame_out    (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] lit(input int d);
        case (d)
            3:       return 4'b0111;
            2:       return 4'b1011;
            1:       return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst%0d anode", i), 32'(anode), 32'hF);
            chk($sformatf("rst%0d digit", i), 32'(digit), 32'hFF);
            chk($sformatf("rst%0d frame", i), 32'(frame), 32'h0);
            chk($sformatf("rst%0d ready", i), 32'(wr_ready), 32'h0);
        end
        rst_n     = 1'b1;
        exp_ready = 1'b1;
        exp_pend  = 1'b0;
    endtask

    // One full scan starting at the next edge; act is the frame expected on display.
    task automatic run_scan(input int row, input logic [3:0] en, input logic [31:0] act,
                            input int w1c, input logic [31:0] w1d,
                            input int w2c, input logic [31:0] w2d);
        int d, pos, c1, c2;
        logic show, acc, pend_old;
        logic [3:0] ea;
        logic [7:0] ed;
        c1 = (w1c == BND) ? P - 1 : w1c;
        c2 = (w2c == BND) ? P - 1 : w2c;
        digit_en = en;
        for (int c = 0; c < P; c++) begin
            if (c == c1) begin
                wr_valid = 1'b1; wr_data = w1d;
            end else if (c == c2) begin
                wr_valid = 1'b1; wr_data = w2d;
            end else begin
                wr_valid = 1'b0; wr_data = 32'h0;
            end
            acc      = wr_valid && exp_ready;
            pend_old = exp_pend;
            @(posedge clk); #1;
            if (acc) begin
                exp_pend  = 1'b1;
                exp_ready = 1'b0;
            end else if (c == P - 1 && pend_old) begin
                exp_pend  = 1'b0;
                exp_ready = 1'b1;
            end
            d    = 3 - c / S;
            pos  = c % S;
            show = (pos < RT) && en[d];
            ea   = show ? lit(d) : 4'hF;
            ed   = show ? act[8*d +: 8] : 8'hFF;
            chk($sformatf("r%0d c%0d anode", row, c), 32'(anode), 32'(ea));
            chk($sformatf("r%0d c%0d digit", row, c), 32'(digit), 32'(ed));
            chk($sformatf("r%0d c%0d frame", row, c), 32'(frame), 32'(c == P - 1));
            chk($sformatf("r%0d c%0d ready", row, c), 32'(wr_ready), 32'(exp_ready));
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 32'h0;
        digit_en = 4'hF;
        exp_ready = 1'b0;
        exp_pend  = 1'b0;

        tbl[0] = '{4'hF, 32'hFFFFFFFF, -1, 32'h0, -1, 32'h0};
        tbl[1] = '{4'hF, 32'hFFFFFFFF, 2, 32'h898686C7, -1, 32'h0};
        tbl[2] = '{4'hF, 32'h898686C7, -1, 32'h0, -1, 32'h0};
        tbl[3] = '{4'hF, 32'h898686C7, 1, 32'h91C0C789, 6, 32'h00000000};
        tbl[4] = '{4'hF, 32'h91C0C789, BND, 32'h86868686, -1, 32'h0};
        tbl[5] = '{4'hF, 32'h91C0C789, -1, 32'h0, -1, 32'h0};
        tbl[6] = '{4'b1010, 32'h86868686, -1, 32'h0, -1, 32'h0};
        tbl[7] = '{4'hF, 32'h86868686, -1, 32'h0, -1, 32'h0};

        do_reset(3);
        for (int r = 0; r < 8; r++) begin
            run_scan(r, tbl[r].en, tbl[r].act, tbl[r].w1c, tbl[r].w1d, tbl[r].w2c, tbl[r].w2d);
        end

        // Pending write, then reset during AN1 SHOW: pending frame discarded.
        digit_en = 4'hF;
        wr_valid = 1'b1;
        wr_data  = 32'h898686C7;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        chk("mid ready low", 32'(wr_ready), 32'h0);
        repeat (2 * S) @(posedge clk);
        #1;
        chk("mid an1 anode", 32'(anode), 32'(4'b1101));
        chk("mid an1 digit", 32'(digit), 32'h86);
        do_reset(2);
        run_scan(8, 4'hF, 32'hFFFFFFFF, -1, 32'h0, -1, 32'h0);
        run_scan(9, 4'hF, 32'hFFFFFFFF, -1, 32'h0, -1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
